// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// Grants are held until the owner drops its request or its burst limit expires.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       REQ,
  output logic [3:0]       GNT,
  output logic [1:0]       SEL,
  output logic             VALID,
  output logic [CNT_W-1:0] HOLD_CNT
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               NO_LIMIT = (MAX_HOLD == 32'd0);

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [3:0]       gnt_r, gnt_s;
  logic [1:0]       sel_r, sel_s;
  logic             valid_r, valid_s;
  logic [CNT_W-1:0] hold_r, hold_s;
  logic             keep_s;
  logic [1:0]       rel_ptr_s;
  logic [1:0]       pick_s;

  // Circular search from ptr upward; lowest offset with a request wins.
  function automatic logic [1:0] pick_idx(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx_v;
    logic [1:0] cand_v;
    idx_v = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand_v = ptr + 2'(k);
      if (req[cand_v]) begin
        idx_v = cand_v;
      end else begin
        idx_v = idx_v;
      end
    end
    return idx_v;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state and next-output decision for both arbitration states.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gnt_s     = gnt_r;
    sel_s     = sel_r;
    valid_s   = valid_r;
    hold_s    = hold_r;
    keep_s    = REQ[sel_r] && (NO_LIMIT || (hold_r < HOLD_LIM));
    rel_ptr_s = sel_r + 2'd1;
    pick_s    = 2'd0;
    case (state_r)
      ST_IDLE: begin
        pick_s = pick_idx(REQ, ptr_r);
        if (REQ != 4'b0000) begin
          state_s = ST_BUSY;
          gnt_s   = onehot4(pick_s);
          sel_s   = pick_s;
          valid_s = 1'b1;
          hold_s  = CNT_ONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (keep_s) begin
          hold_s = (hold_r == CNT_MAX) ? CNT_MAX : hold_r + CNT_ONE;
        end else begin
          // The owner sits last in the search from o+1, so a lone owner is regranted.
          ptr_s  = rel_ptr_s;
          pick_s = pick_idx(REQ, rel_ptr_s);
          if (REQ != 4'b0000) begin
            gnt_s   = onehot4(pick_s);
            sel_s   = pick_s;
            valid_s = 1'b1;
            hold_s  = CNT_ONE;
          end else begin
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
            valid_s = 1'b0;
            hold_s  = {CNT_W{1'b0}};
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
        valid_s = 1'b0;
        hold_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      valid_r <= 1'b0;
      hold_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      valid_r <= valid_s;
      hold_r  <= hold_s;
    end
  end

  assign GNT      = gnt_r;
  assign SEL      = sel_r;
  assign VALID    = valid_r;
  assign HOLD_CNT = hold_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (MAX_HOLD 3, 0, 2) share REQ and are
// compared every cycle against a behavioural owner/pointer model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] REQ;

  logic [3:0] gnt_a   [3];
  logic [1:0] sel_a   [3];
  logic       valid_a [3];
  logic [7:0] hold_a  [3];

  int mh      [3] = '{3, 0, 2};
  int owner   [3];
  int ptr     [3];
  int held    [3];
  int lastsel [3];

  int total_checks;
  int passed_checks;

  mux4_rr_arbiter #(.MAX_HOLD(3), .CNT_W(8)) dut_h3 (
    .clk(clk), .rst_n(rst_n), .REQ(REQ),
    .GNT(gnt_a[0]), .SEL(sel_a[0]), .VALID(valid_a[0]), .HOLD_CNT(hold_a[0]));
  mux4_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .REQ(REQ),
    .GNT(gnt_a[1]), .SEL(sel_a[1]), .VALID(valid_a[1]), .HOLD_CNT(hold_a[1]));
  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut_h2 (
    .clk(clk), .rst_n(rst_n), .REQ(REQ),
    .GNT(gnt_a[2]), .SEL(sel_a[2]), .VALID(valid_a[2]), .HOLD_CNT(hold_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total_checks++;
    if (act == exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      owner[i] = -1; ptr[i] = 0; held[i] = 0; lastsel[i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int i = 0; i < 3; i++) begin
      if (owner[i] < 0) begin
        if (r != 4'b0000) begin
          owner[i] = search(r, ptr[i]); held[i] = 1;
        end
      end else if (r[owner[i]] && (mh[i] == 0 || held[i] < mh[i])) begin
        held[i] = (held[i] >= 255) ? 255 : held[i] + 1;
      end else begin
        ptr[i] = (owner[i] + 1) % 4;
        if (r != 4'b0000) begin
          owner[i] = search(r, ptr[i]); held[i] = 1;
        end else begin
          owner[i] = -1; held[i] = 0;
        end
      end
      if (owner[i] >= 0) lastsel[i] = owner[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("gnt", i, int'(gnt_a[i]), (owner[i] < 0) ? 0 : (1 << owner[i]));
      chk("sel", i, int'(sel_a[i]), lastsel[i]);
      chk("valid", i, int'(valid_a[i]), (owner[i] < 0) ? 0 : 1);
      chk("hold_cnt", i, int'(hold_a[i]), held[i]);
      chk("onehot0", i, int'($onehot0(gnt_a[i])), 1);
      if (valid_a[i]) chk("sel_vs_gnt", i, int'(gnt_a[i]), 1 << sel_a[i]);
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    REQ = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all();
  endtask

  // Reset lands mid-cycle, away from any clock edge, to show it is asynchronous.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    REQ   = 4'b0000;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n = 1'b0;
    REQ   = 4'b0000;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then reset mid-grant.
    cycle(4'b0100);
    chk("t1_gnt", 0, int'(gnt_a[0]), 4);
    chk("t1_sel", 0, int'(sel_a[0]), 2);
    chk("t1_valid", 0, int'(valid_a[0]), 1);
    cycle(4'b0100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_gnt", 0, int'(gnt_a[0]), 0);
    chk("t1_rst_valid", 0, int'(valid_a[0]), 0);
    chk("t1_rst_hold", 0, int'(hold_a[0]), 0);
    REQ = 4'b0000;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention with MAX_HOLD=3.
    for (int c = 0; c < 24; c++) begin
      cycle(4'b1111);
      chk("t2_gnt", 0, int'(gnt_a[0]), 1 << ((c / 3) % 4));
      chk("t2_hold", 0, int'(hold_a[0]), (c % 3) + 1);
      chk("t2_valid", 0, int'(valid_a[0]), 1);
    end

    // Unlimited hold, saturating counter, then handover without a gap.
    async_reset();
    for (int c = 0; c < 300; c++) cycle(4'b0011);
    chk("t3_gnt", 1, int'(gnt_a[1]), 1);
    chk("t3_hold_sat", 1, int'(hold_a[1]), 255);
    cycle(4'b0010);
    chk("t3_handover_gnt", 1, int'(gnt_a[1]), 2);
    chk("t3_handover_sel", 1, int'(sel_a[1]), 1);
    chk("t3_handover_valid", 1, int'(valid_a[1]), 1);

    // Owner 2 drops while 0 and 3 request: pointer 3 picks requester 3.
    async_reset();
    cycle(4'b0100);
    cycle(4'b1001);
    chk("t4_gnt", 1, int'(gnt_a[1]), 8);

    // Lone requester with MAX_HOLD=2 is regranted, then released.
    async_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(4'b0001);
      chk("t5_gnt", 2, int'(gnt_a[2]), 1);
      chk("t5_hold", 2, int'(hold_a[2]), (c % 2) + 1);
    end
    cycle(4'b0000);
    chk("t5_idle_gnt", 2, int'(gnt_a[2]), 0);
    chk("t5_idle_valid", 2, int'(valid_a[2]), 0);
    chk("t5_idle_sel", 2, int'(sel_a[2]), 0);

    // Every REQ pattern from IDLE with each pointer position.
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        async_reset();
        if (p > 0) begin
          cycle(4'(1 << (p - 1)));
          cycle(4'b0000);
        end
        cycle(4'(r));
      end
    end

    // Randomised traffic with occasional asynchronous resets.
    begin
      logic [3:0] rr;
      rr = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 499) == 0) async_reset();
        else cycle(rr);
      end
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
